// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO (shared shift-add / restoring datapath).
// Optional MULDIV_EARLY_OUT_EN: multiply stops once remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            dbz
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, sa, sb;
  logic [XLEN-1:0]   opa, opb;
  logic [2*XLEN:0]   acc, acc_n;
  logic              last;

  logic              in_sa, in_sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     sum, trial, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, hi_fin, lo_fin;

  assign in_sa = ~op[0] & rs_val[XLEN-1];
  assign in_sb = ~op[0] & rt_val[XLEN-1];
  assign abs_a = in_sa ? -rs_val : rs_val;
  assign abs_b = in_sb ? -rt_val : rt_val;
  assign busy  = (state != IDLE);

  assign sum   = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opa} : '0);
  assign trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff  = trial - {1'b0, opb};

`ifdef MULDIV_EARLY_OUT_EN
  assign last = (cnt == CNT_W'(XLEN-1)) ||
                (!is_div && ((opb >> (cnt + CNT_W'(1))) == '0));
`else
  assign last = (cnt == CNT_W'(XLEN-1));
`endif

  always_comb begin
    acc_n = acc;
    if (is_div) begin
      if (diff[XLEN])
        acc_n = {1'b0, trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_n = {1'b0, diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_n = {1'b0, sum, acc[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
      // skip the all-zero tail: pure shifts, same final product
      if (last)
        acc_n = acc_n >> (CNT_W'(XLEN-1) - cnt);
`endif
    end
  end

  always_comb begin
    prod   = acc[2*XLEN-1:0];
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    hi_fin = rem;
    lo_fin = quo;
    if (!is_div) begin
      if (sa ^ sb)
        prod = -prod;
      hi_fin = prod[2*XLEN-1:XLEN];
      lo_fin = prod[XLEN-1:0];
    end else if (opb == '0) begin
      hi_fin = sa ? -opa : opa;
      lo_fin = '1;
    end else begin
      hi_fin = sa ? -rem : rem;
      lo_fin = (sa ^ sb) ? -quo : quo;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sa     <= in_sa;
            sb     <= in_sb;
            opa    <= abs_a;
            opb    <= abs_b;
            acc    <= {{(XLEN+1){1'b0}}, op[1] ? abs_a : abs_b};
            cnt    <= '0;
            dbz    <= 1'b0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_n;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          hi   <= hi_fin;
          lo   <= lo_fin;
          done <= 1'b1;
          dbz  <= is_div && (opb == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
